// File: rtl/free_list_multiport.sv
// Multi-port circular free list of physical register indexes for rename (alloc) and commit (free).
// Allocation is a combinational read; the read pointer can be restored in one cycle on a flush.
module free_list_multiport #(
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned ALLOC_WIDTH   = 2,
    parameter int unsigned FREE_WIDTH    = 2,
    localparam int unsigned PRW   = $clog2(NUM_PHYS_REGS),
    localparam int unsigned DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ALLOC_WIDTH-1:0]       alloc_req,
    output logic                         alloc_ready,
    output logic [ALLOC_WIDTH*PRW-1:0]   alloc_preg,
    input  logic [FREE_WIDTH-1:0]        free_valid,
    input  logic [FREE_WIDTH*PRW-1:0]    free_preg,
    input  logic                         restore_valid,
    input  logic [AW:0]                  restore_rptr,
    output logic [AW:0]                  rptr_out,
    output logic [AW:0]                  count,
    output logic                         overflow_err
);

    localparam logic [AW:0] DEPTH_PTR = (AW+1)'(DEPTH);

    logic [PRW-1:0] entry_q [DEPTH];
    logic [PRW-1:0] entry_d [DEPTH];
    logic [AW:0]    rptr_q, rptr_d;
    logic [AW:0]    wptr_q, wptr_d;
    logic           overflow_q, overflow_d;

    logic [AW:0]    n_alloc, n_free, space;
    logic [AW-1:0]  alloc_off [ALLOC_WIDTH];
    logic [AW-1:0]  free_off [FREE_WIDTH];
    logic           free_ok;

    assign count        = wptr_q - rptr_q;
    assign space        = DEPTH_PTR - count;
    assign rptr_out     = rptr_q;
    assign overflow_err = overflow_q;

    // Lanes are compacted: each requesting lane takes the next entry after earlier requesters.
    always_comb begin
        n_alloc    = '0;
        alloc_preg = '0;
        for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
            alloc_off[i] = n_alloc[AW-1:0];
            n_alloc      = n_alloc + (AW+1)'(alloc_req[i]);
        end
        for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
            alloc_preg[i*PRW +: PRW] = entry_q[rptr_q[AW-1:0] + alloc_off[i]];
        end
        alloc_ready = (count >= n_alloc) && !restore_valid;
    end

    always_comb begin
        n_free = '0;
        for (int j = 0; j < int'(FREE_WIDTH); j++) begin
            free_off[j] = n_free[AW-1:0];
            n_free      = n_free + (AW+1)'(free_valid[j]);
        end
        free_ok    = (n_free <= space);
        entry_d    = entry_q;
        wptr_d     = wptr_q;
        overflow_d = overflow_q;
        // An over-subscribed free batch is dropped whole and flagged.
        if (free_ok) begin
            for (int j = 0; j < int'(FREE_WIDTH); j++) begin
                if (free_valid[j]) begin
                    entry_d[wptr_q[AW-1:0] + free_off[j]] = free_preg[j*PRW +: PRW];
                end
            end
            wptr_d = wptr_q + n_free;
        end else begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        rptr_d = rptr_q;
        if (restore_valid) begin
            rptr_d = restore_rptr;
        end else if (alloc_ready) begin
            rptr_d = rptr_q + n_alloc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= PRW'(i + int'(NUM_ARCH_REGS));
            end
            rptr_q     <= '0;
            wptr_q     <= DEPTH_PTR;
            overflow_q <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
